jtag_tap_shifter: RTL and testbench

Serial JTAG master for the CSM daisy chain. On a start request it walks the TAP from Run-Test/Idle through Shift-DR or Shift-IR. It shifts total_bits = bit_length*device_count TDI bits out, LSB first, while capturing TDO. Captured bits enter the MSB end of the 4096-bit JTAG_data_out register, which is the format the downstream TDO alignment stage right-justifies by shifting 4096-total_bits places.

---
 rtl/jtag_tap_shifter_if.sv | 29 ++
 rtl/jtag_tap_shifter.sv | 134 +++++++++++++
 tb/tb_jtag_tap_shifter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_shifter_if.sv
// Bundle of the scan request/result signals and the JTAG pins of jtag_tap_shifter.
// The master side issues scans and drives the chain's TDO; the slave side is the shifter.
interface jtag_tap_shifter_if #(
  parameter int unsigned MaxBits = 4096
);
  logic               start;
  logic               ir_sel;
  logic [MaxBits-1:0] tdi_data;
  logic [7:0]         bit_length;
  logic [4:0]         device_count;
  logic               tdo;
  logic               tck;
  logic               tms;
  logic               tdi;
  logic [MaxBits-1:0] JTAG_data_out;
  logic               busy;
  logic               done;
  logic               len_err;

  modport master (
    output start, ir_sel, tdi_data, bit_length, device_count, tdo,
    input  tck, tms, tdi, JTAG_data_out, busy, done, len_err
  );

  modport slave (
    input  start, ir_sel, tdi_data, bit_length, device_count, tdo,
    output tck, tms, tdi, JTAG_data_out, busy, done, len_err
  );
endinterface

// File: rtl/jtag_tap_shifter.sv
// Serial JTAG master: walks the TAP from Run-Test/Idle through Shift-DR/IR, shifts
// bit_length*device_count bits LSB first and captures TDO into an MSB-entry register.
module jtag_tap_shifter #(
  parameter int unsigned TCK_HALF = 4,
  parameter int unsigned MAX_BITS = 4096
) (
  input logic              clk,
  input logic              rst_n,
  jtag_tap_shifter_if.slave bus
);

  localparam int unsigned PhW    = $clog2(2 * TCK_HALF);
  localparam logic [PhW-1:0] PhRise = PhW'(TCK_HALF - 1);
  localparam logic [PhW-1:0] PhHigh = PhW'(TCK_HALF);
  localparam logic [PhW-1:0] PhLast = PhW'(2 * TCK_HALF - 1);
  localparam logic [12:0]    MaxN   = 13'(MAX_BITS);

  typedef enum logic [3:0] {
    StIdle, StSelDr, StSelIr, StCapture, StToShift, StShift, StExit1, StUpdate, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          start_q, start_d;
  logic [PhW-1:0]      ph_q, ph_d;
  logic [12:0]         cnt_q, cnt_d;
  logic [12:0]         n_q, n_d;
  logic                ir_q, ir_d;
  logic                err_q, err_d;
  logic [MAX_BITS-1:0] tdi_sr_q, tdi_sr_d;
  logic [MAX_BITS-1:0] data_q, data_d;

  logic        start_edge, n_bad, period_end, rise, last_bit, active;
  logic [12:0] n_calc;

  assign start_edge = ~start_q[1] & start_q[0];
  assign n_calc     = 13'(bus.bit_length) * 13'(bus.device_count);
  assign n_bad      = (n_calc == 13'd0) || (n_calc > MaxN);
  assign period_end = (ph_q == PhLast);
  assign rise       = (ph_q == PhRise);
  assign last_bit   = (cnt_q == n_q - 13'd1);
  assign active     = (state_q != StIdle) && (state_q != StDone);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; non-idle states advance only where tck falls
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start_edge) state_d = n_bad ? StDone : StSelDr;
      StSelDr:   if (period_end) state_d = ir_q ? StSelIr : StCapture;
      StSelIr:   if (period_end) state_d = StCapture;
      StCapture: if (period_end) state_d = StToShift;
      StToShift: if (period_end) state_d = StShift;
      StShift:   if (period_end && last_bit) state_d = StExit1;
      StExit1:   if (period_end) state_d = StUpdate;
      StUpdate:  if (period_end) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy    = active;
    bus.done    = (state_q == StDone);
    bus.len_err = (state_q == StDone) && err_q;
    bus.tck     = active && (ph_q >= PhHigh);
    bus.tdi     = (state_q == StShift) && tdi_sr_q[0];
    unique case (state_q)
      StCapture, StToShift, StUpdate: bus.tms = 1'b0;
      StShift:                        bus.tms = last_bit;
      default:                        bus.tms = 1'b1;
    endcase
  end

  assign bus.JTAG_data_out = data_q;

  always_comb begin
    start_d  = {start_q[0], bus.start};
    ph_d     = (active && !period_end) ? ph_q + PhW'(1) : '0;
    cnt_d    = cnt_q;
    n_d      = n_q;
    ir_d     = ir_q;
    err_d    = err_q;
    tdi_sr_d = tdi_sr_q;
    data_d   = data_q;
    if (state_q == StIdle && start_edge) begin
      cnt_d    = '0;
      n_d      = n_calc;
      ir_d     = bus.ir_sel;
      err_d    = n_bad;
      tdi_sr_d = bus.tdi_data;
      data_d   = '0;
    end else if (state_q == StShift) begin
      if (rise) begin
        data_d = {bus.tdo, data_q[MAX_BITS-1:1]};
      end
      if (period_end) begin
        cnt_d    = last_bit ? '0 : cnt_q + 13'd1;
        tdi_sr_d = tdi_sr_q >> 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= '0;
      ph_q     <= '0;
      cnt_q    <= '0;
      n_q      <= '0;
      ir_q     <= 1'b0;
      err_q    <= 1'b0;
      tdi_sr_q <= '0;
      data_q   <= '0;
    end else begin
      start_q  <= start_d;
      ph_q     <= ph_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      ir_q     <= ir_d;
      err_q    <= err_d;
      tdi_sr_q <= tdi_sr_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_jtag_tap_shifter.sv
// Scoreboard bench for jtag_tap_shifter: scans are issued with a predicted outcome queued,
// and a monitor compares tck/tms activity, timing and captured data at each done pulse.
module tb_jtag_tap_shifter;
  localparam int unsigned TH = 2;
  localparam int unsigned MB = 4096;

  typedef struct {
    logic           len_err;
    logic [MB-1:0]  data;
    logic [MB+7:0]  tms;
    int             rises;
    int             cycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tdo_mode = 0;
  logic tdo_const = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_dones = 0;
  int done_cnt = 0;

  exp_t sb[$];

  int            mon_rises = 0;
  int            mon_cyc = 0;
  logic          prev_tck = 1'b0;
  logic          prev_done = 1'b0;
  logic [MB+7:0] tms_got = '0;

  jtag_tap_shifter_if #(.MaxBits(MB)) bus ();

  assign bus.tdo = (tdo_mode == 0) ? bus.tdi : (tdo_mode == 1) ? tdo_const : ~bus.tdi;

  jtag_tap_shifter #(.TCK_HALF(TH), .MAX_BITS(MB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [MB-1:0] got, input logic [MB-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got[4095:4032]=%h [63:0]=%h expected [4095:4032]=%h [63:0]=%h",
               nm, got[MB-1:MB-64], got[63:0], exp[MB-1:MB-64], exp[63:0]);
    end
  endtask

  // Monitor: accumulates activity per scan and checks it against the queue head on done.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_rises = 0;
      mon_cyc   = 0;
      prev_tck  = 1'b0;
      prev_done = 1'b0;
      tms_got   = '0;
    end else begin
      if (bus.busy) mon_cyc++;
      if (bus.tck && !prev_tck) begin
        if (mon_rises < MB + 8) tms_got[mon_rises] = bus.tms;
        mon_rises++;
      end
      prev_tck = bus.tck;
      if (bus.done) begin
        done_cnt++;
        chk("done_width", {63'd0, prev_done}, 64'd0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no scan pending");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("len_err", {63'd0, bus.len_err}, {63'd0, e.len_err});
          chk("tck_rises", 64'(mon_rises), 64'(e.rises));
          chk("busy_cycles", 64'(mon_cyc), 64'(e.cycles));
          n_cmp++;
          if (tms_got !== e.tms) begin
            n_fail++;
            $display("FAIL tms_seq: got low bits %h expected %h", tms_got[63:0], e.tms[63:0]);
          end
          chk_data("data_out", bus.JTAG_data_out, e.data);
        end
        mon_rises = 0;
        mon_cyc   = 0;
        tms_got   = '0;
      end
      prev_done = bus.done;
    end
  end

  function automatic exp_t predict(input logic ir, input int n, input int mode, input logic tc,
                                   input logic [MB-1:0] td);
    exp_t e;
    int   idx;
    int   periods;
    logic cap;
    e.len_err = 1'b0;
    e.data    = '0;
    e.tms     = '0;
    e.rises   = 0;
    e.cycles  = 0;
    if (n == 0 || n > MB) begin
      e.len_err = 1'b1;
    end else begin
      periods  = n + (ir ? 6 : 5);
      e.rises  = periods;
      e.cycles = 2 * TH * periods;
      idx = 0;
      e.tms[idx] = 1'b1; idx++;
      if (ir) begin e.tms[idx] = 1'b1; idx++; end
      e.tms[idx] = 1'b0; idx++;
      e.tms[idx] = 1'b0; idx++;
      for (int k = 0; k < n; k++) begin
        e.tms[idx] = (k == n - 1); idx++;
      end
      e.tms[idx] = 1'b1; idx++;
      e.tms[idx] = 1'b0;
      for (int k = 0; k < n; k++) begin
        cap = (mode == 0) ? td[k] : (mode == 1) ? tc : ~td[k];
        e.data[MB - n + k] = cap;
      end
    end
    return e;
  endfunction

  task automatic pulse_start();
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic issue(input logic ir, input int bl, input int dc, input int mode,
                       input logic tc, input logic [MB-1:0] td);
    sb.push_back(predict(ir, bl * dc, mode, tc, td));
    exp_dones++;
    bus.ir_sel       = ir;
    bus.bit_length   = 8'(bl);
    bus.device_count = 5'(dc);
    bus.tdi_data     = td;
    tdo_mode         = mode;
    tdo_const        = tc;
    pulse_start();
  endtask

  task automatic wait_drain(input int n);
    int g;
    g = 0;
    while (sb.size() != 0 && g < 2 * TH * (n + 6) + 100) begin
      @(posedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scan_timeout: got no done after %0d clk expected done", g);
      sb.delete();
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input logic ir, input int bl, input int dc, input int mode,
                          input logic tc, input logic [MB-1:0] td);
    issue(ir, bl, dc, mode, tc, td);
    wait_drain(bl * dc);
  endtask

  function automatic logic [MB-1:0] rand_vec();
    logic [MB-1:0] v;
    for (int i = 0; i < MB / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected $finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [MB-1:0] td;
    int g;
    bus.start = 1'b0;
    bus.ir_sel = 1'b0;
    bus.bit_length = '0;
    bus.device_count = '0;
    bus.tdi_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tck", {63'd0, bus.tck}, 64'd0);
    chk("rst_tms", {63'd0, bus.tms}, 64'd1);
    chk("rst_tdi", {63'd0, bus.tdi}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_len_err", {63'd0, bus.len_err}, 64'd0);
    chk_data("rst_data", bus.JTAG_data_out, '0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    td = '0;
    td[15:0] = 16'hA5C3;
    run_scan(1'b0, 8, 2, 0, 1'b0, td);
    run_scan(1'b1, 8, 2, 0, 1'b0, td);
    run_scan(1'b0, 128, 31, 1, 1'b1, rand_vec());
    run_scan(1'b1, 195, 21, 2, 1'b0, rand_vec());
    run_scan(1'b0, 0, 5, 0, 1'b0, rand_vec());
    run_scan(1'b0, 255, 31, 0, 1'b0, rand_vec());
    run_scan(1'b1, 241, 17, 0, 1'b0, rand_vec());
    run_scan(1'b0, 1, 1, 2, 1'b0, rand_vec());

    // Second start while busy must not produce a second scan.
    issue(1'b0, 8, 2, 0, 1'b0, td);
    repeat (20) @(posedge clk);
    #1 pulse_start();
    wait_drain(16);

    for (int i = 0; i < 10; i++) begin
      run_scan(1'($urandom_range(0, 1)), int'($urandom_range(1, 24)),
               int'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)), rand_vec());
    end

    // Abort during Shift-DR.
    issue(1'b0, 8, 2, 0, 1'b0, rand_vec());
    exp_dones--;
    g = 0;
    while (mon_rises < 8 && g < 500) begin
      @(posedge clk);
      g++;
    end
    chk("reached_shift", 64'(mon_rises >= 8), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_tck", {63'd0, bus.tck}, 64'd0);
    chk("abort_tms", {63'd0, bus.tms}, 64'd1);
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk_data("abort_data", bus.JTAG_data_out, '0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_scan(1'b1, 8, 2, 0, 1'b0, td);

    chk("done_count", 64'(done_cnt), 64'(exp_dones));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
